// File: rtl/slave_wr_ctrl_pkg.sv
// Shared definitions for the master-write-bus slave: FSM encoding, address shift, burst-length helpers.
package slave_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } wr_state_e;

  localparam int WORD_SHIFT = 2;
  localparam int BLEN_W     = 8;

  function automatic logic [BLEN_W-1:0] sat_inc(input logic [BLEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/slave_wr_ctrl_req_sync.sv
// Two-flop synchronizer with asynchronous active-high reset; shared by the write and read slaves.
module req_sync (
  input  logic iClk,
  input  logic iRst,
  input  logic async_in,
  output logic sync_out
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= async_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync_out = sync_reg;

endmodule

// File: rtl/slave_wr_ctrl.sv
// Write-bus slave: handshakes single and burst beats with programmable wait states and
// replays each accepted beat onto a registered byte-enabled memory write port.
module slave_wr_ctrl
  import slave_wr_ctrl_pkg::*;
#(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int SW       = 4,
  parameter int WAIT_CYC = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iSlvWrReq,
  input  logic                  iSlvWrValid,
  input  logic [AW-1:0]         iSlvWrAddr,
  input  logic [SW-1:0]         iSlvWrSel,
  input  logic                  iSlvWrLast,
  input  logic [DW-1:0]         iSlvWrData,
  output logic                  oSlvWrReady,
  output logic                  oMemWrEn,
  output logic [AW-3:0]         oMemWrAddr,
  output logic [SW-1:0]         oMemWrBe,
  output logic [DW-1:0]         oMemWrData,
  output logic                  oBurstDone,
  output logic [BLEN_W-1:0]     oBurstLen,
  output logic                  oErrAlign,
  output logic                  oErrProto,
  input  logic                  iErrClr
);

  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYC);

  logic              req_s;
  wr_state_e         state_reg, state_next;
  logic [3:0]        wait_cnt_reg, wait_cnt_next;
  logic [BLEN_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic              accept, burst_end, proto_set;

  req_sync u_req_sync (
    .iClk     (iClk),
    .iRst     (iRst),
    .async_in (iSlvWrReq),
    .sync_out (req_s)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    accept        = 1'b0;
    burst_end     = 1'b0;
    proto_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_s) begin
          state_next    = ST_WAIT;
          wait_cnt_next = '0;
          beat_cnt_next = '0;
        end
      end
      ST_WAIT: begin
        // Losing the request mid-burst is a protocol error; the burst is abandoned.
        if (!req_s) begin
          state_next = ST_IDLE;
          proto_set  = 1'b1;
        end else if (iSlvWrValid) begin
          if (wait_cnt_reg == WAIT_LIM) state_next = ST_ACK;
          else                          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_ACK: begin
        wait_cnt_next = '0;
        if (iSlvWrValid) begin
          accept        = 1'b1;
          beat_cnt_next = sat_inc(beat_cnt_reg);
          if (iSlvWrLast) begin
            state_next = ST_DONE;
            burst_end  = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end else begin
          proto_set  = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        // Wait for the request to fall so a stale request cannot start a new burst.
        if (!req_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign oSlvWrReady = (state_reg == ST_ACK);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oMemWrEn   <= 1'b0;
      oMemWrAddr <= '0;
      oMemWrBe   <= '0;
      oMemWrData <= '0;
      oBurstDone <= 1'b0;
      oBurstLen  <= '0;
      oErrAlign  <= 1'b0;
      oErrProto  <= 1'b0;
    end else begin
      oMemWrEn   <= accept && (|iSlvWrSel);
      oBurstDone <= burst_end;
      if (accept) begin
        oMemWrAddr <= iSlvWrAddr[AW-1:WORD_SHIFT];
        oMemWrBe   <= iSlvWrSel;
        oMemWrData <= iSlvWrData;
      end
      if (burst_end) oBurstLen <= beat_cnt_next;
      if (iErrClr)                                oErrAlign <= 1'b0;
      else if (accept && (|iSlvWrAddr[1:0]))      oErrAlign <= 1'b1;
      if (iErrClr)        oErrProto <= 1'b0;
      else if (proto_set) oErrProto <= 1'b1;
    end
  end

endmodule
